// File: rtl/accelbrot_com_axi_fifo_slice.sv
// Registered-output stream FIFO slice: DEPTH words total (storage + output register),
// latency 1 when empty, full throughput on simultaneous push/pop, flush and sync reset.
module accelbrot_com_axi_fifo_slice #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           flush,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_last,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(DEPTH+1)-1:0]     level,
   output logic                           almost_full
);

   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = DATA_WIDTH + 1;

   // Storage entries carry {last, data}
   logic [ENT_W-1:0]      mem_q [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  in_ready_q, in_ready_d;
   logic                  afull_q, afull_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;

   logic                  push_c;
   logic                  pop_c;
   logic                  load_c;
   logic                  bypass_c;
   logic                  mem_we_c;
   logic [LVL_W-1:0]      stored_c;
   logic [ENT_W-1:0]      head_c;

   assign push_c   = in_valid & in_ready_q;
   assign pop_c    = out_valid_q & out_ready;
   // Words sitting behind the output register
   assign stored_c = level_q - LVL_W'(out_valid_q);
   assign load_c   = ~out_valid_q | pop_c;
   assign bypass_c = load_c & (stored_c == '0) & push_c;
   assign mem_we_c = push_c & ~bypass_c;
   assign head_c   = mem_q[rd_ptr_q];

   // Next-state: refill the output register from storage first, else straight from the input
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (load_c) begin
         if (stored_c != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = head_c[DATA_WIDTH-1:0];
            out_last_d  = head_c[DATA_WIDTH];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
         end else if (push_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = in_last;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      if (mem_we_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      level_d    = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      in_ready_d = (level_d < LVL_W'(DEPTH));
      afull_d    = (level_d >= LVL_W'(AFULL_LEVEL));
   end

   // State register: reset beats flush, flush beats any handshake
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         in_ready_q  <= 1'b0;
         afull_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         in_ready_q  <= 1'b1;
         afull_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         in_ready_q  <= in_ready_d;
         afull_q     <= afull_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Storage array is not reset; pointers alone define its valid contents
   always_ff @(posedge clk) begin
      if (rstn && !flush && mem_we_c) begin
         mem_q[wr_ptr_q] <= {in_last, in_data};
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;
   assign level       = level_q;
   assign almost_full = afull_q;

endmodule

// File: tb/tb_accelbrot_com_axi_fifo_slice.sv
// Bench for accelbrot_com_axi_fifo_slice: directed and random traffic checked every
// cycle against a queue model of the FIFO contents.
module tb_accelbrot_com_axi_fifo_slice;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AFULL = 3;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    level;
   logic          almost_full;

   int n_checks = 0;
   int n_errors = 0;

   // Model: accepted-but-not-delivered words as {last, data}, plus expected in_ready
   logic [DW:0] mdl_q[$];
   logic        mdl_rdy = 1'b0;

   accelbrot_com_axi_fifo_slice #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AFULL_LEVEL(AFULL)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, compare outputs
   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic r, input logic f, input logic rn);
      logic do_push;
      logic do_pop;
      int   sz;
      rstn      = rn;
      flush     = f;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      do_push   = v && mdl_rdy;
      do_pop    = r && (mdl_q.size() > 0);
      @(posedge clk);
      if (!rn) begin
         mdl_q.delete();
         mdl_rdy = 1'b0;
      end else if (f) begin
         mdl_q.delete();
         mdl_rdy = 1'b1;
      end else begin
         if (do_pop)  void'(mdl_q.pop_front());
         if (do_push) mdl_q.push_back({l, d});
         mdl_rdy = (mdl_q.size() < DEPTH);
      end
      #1;
      sz = mdl_q.size();
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      check("level", 32'(level), 32'(sz));
      check("in_ready", 32'(in_ready), 32'(mdl_rdy));
      check("almost_full", 32'(almost_full), 32'(sz >= AFULL));
      if (sz != 0) begin
         check("out_data", 32'(out_data), 32'(mdl_q[0][DW-1:0]));
         check("out_last", 32'(out_last), 32'(mdl_q[0][DW]));
      end
      if (!rn) begin
         check("rst_out_data", 32'(out_data), 32'h0);
         check("rst_out_last", 32'(out_last), 32'h0);
      end
   endtask

   initial begin
      int idx;
      int sent;
      int cycles;
      logic v;
      logic acc;
      logic [DW-1:0] pend_d;
      logic pend_l;

      // Reset then idle
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

      // Fill with downstream stalled, then drain; 0x15 must wait for space
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         v   = (idx < 5);
         acc = v && mdl_rdy;
         cyc(v, 8'(8'h11 + idx), 1'b0, 1'b0, 1'b0, 1'b1);
         if (acc) idx++;
      end
      check("fill_count", 32'(idx), 32'd4);
      for (int i = 0; i < 10; i++) begin
         v   = (idx < 5);
         acc = v && mdl_rdy;
         cyc(v, 8'(8'h11 + idx), 1'b0, 1'b1, 1'b0, 1'b1);
         if (acc) idx++;
      end
      check("drain_all_sent", 32'(idx), 32'd5);

      // Full-rate streaming with out_ready held high
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 8'(i), (i == 63), 1'b1, 1'b0, 1'b1);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

      // Random valid/ready; payload held until accepted
      sent   = 0;
      cycles = 0;
      pend_d = 8'($urandom);
      pend_l = 1'($urandom);
      while (sent < 1000 && cycles < 20000) begin
         v   = 1'($urandom);
         acc = v && mdl_rdy;
         cyc(v, pend_d, pend_l, 1'($urandom), 1'b0, 1'b1);
         cycles++;
         if (acc) begin
            sent++;
            pend_d = 8'($urandom);
            pend_l = 1'($urandom);
         end
      end
      check("random_sent", 32'(sent), 32'd1000);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

      // Flush at level 3 with live handshakes on both sides
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      check("pre_flush_level", 32'(level), 32'd3);
      cyc(1'b1, 8'h3F, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

      // One-cycle reset mid-stream at level 2, then a lone 0xA5
      cyc(1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pre_reset_level", 32'(level), 32'd2);
      cyc(1'b1, 8'h53, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      check("a5_alone", 32'({out_valid, out_last, out_data, level}), 32'({1'b1, 1'b1, 8'hA5, 3'd1}));
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
